// File: rtl/noise_gen_multi.sv
// Multi-channel pitched noise source: per-channel phase accumulator clocks a 23-bit LFSR
// on each accumulator MSB rising edge, with long/short feedback, test hold and seed load.
module noise_gen_multi #(
  parameter int          NCH    = 3,
  parameter int          FREQ_W = 16,
  parameter int          ACC_W  = 24,
  parameter logic [22:0] SEED   = 23'h37242B
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic [NCH*FREQ_W-1:0]                  freq,
  input  logic [NCH-1:0]                         mode,
  input  logic [NCH-1:0]                         test,
  input  logic                                   seed_wr,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] seed_ch,
  input  logic [22:0]                            seed_data,
  output logic [NCH*8-1:0]                       dout,
  output logic [NCH-1:0]                         step
);

  function automatic logic [7:0] taps(input logic [22:0] l);
    return {l[22], l[20], l[16], l[13], l[11], l[7], l[4], l[2]};
  endfunction

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [22:0]      lfsr;
    logic [22:0]      lfsr_next;
    logic             step_hit;
    logic             seed_hit;
    logic             locked;
    logic             step_q;
    logic [7:0]       dout_q;

    always_comb begin
      acc_next  = en ? acc + ACC_W'(freq[k*FREQ_W +: FREQ_W]) : acc;
      step_hit  = en & ~acc[ACC_W-1] & acc_next[ACC_W-1];
      seed_hit  = seed_wr && (int'(seed_ch) == k);
      locked    = mode[k] ? (lfsr[14:0] == '0) : (lfsr == '0);
      lfsr_next = lfsr;
      if (test[k])
        lfsr_next = SEED;
      else if (seed_hit)
        lfsr_next = (seed_data == '0) ? SEED : seed_data;
      else if (step_hit)
        lfsr_next = locked ? SEED
                           : {lfsr[21:0], mode[k] ? (lfsr[14] ^ lfsr[13]) : (lfsr[22] ^ lfsr[17])};
    end

    // dout is registered from lfsr_next so it changes on the same edge as lfsr
    always_ff @(posedge clk) begin
      if (rst) begin
        acc    <= '0;
        lfsr   <= SEED;
        step_q <= 1'b0;
        dout_q <= taps(SEED);
      end else begin
        acc    <= test[k] ? '0 : acc_next;
        lfsr   <= lfsr_next;
        step_q <= step_hit & ~test[k] & ~seed_hit;
        dout_q <= taps(lfsr_next);
      end
    end

    assign dout[k*8 +: 8] = dout_q;
    assign step[k]        = step_q;
  end

endmodule

// File: tb/tb_noise_gen_multi.sv
// Scoreboard bench for noise_gen_multi: a cycle model pushes expected {step,dout} per edge,
// plus directed checks and a short-mode period run on a narrow-accumulator instance.
module tb_noise_gen_multi;
  localparam int          NCH  = 3;
  localparam int          FW   = 16;
  localparam int          AW   = 24;
  localparam logic [22:0] SEED = 23'h37242B;

  logic              clk = 1'b0;
  logic              rst, en, seed_wr;
  logic [NCH*FW-1:0] freq;
  logic [NCH-1:0]    mode, test, step;
  logic [1:0]        seed_ch;
  logic [22:0]       seed_data;
  logic [NCH*8-1:0]  dout;

  logic        r2, en2, sw2, step2;
  logic [15:0] freq2;
  logic [0:0]  mode2, test2, sch2, step2_v;
  logic [22:0] sd2;
  logic [7:0]  dout2;

  int n_checks = 0;
  int n_err    = 0;

  logic [AW-1:0]      m_acc [NCH];
  logic [22:0]        m_lfsr[NCH];
  logic [NCH*8+NCH-1:0] sb[$];

  always #5 clk = ~clk;

  noise_gen_multi #(.NCH(NCH), .FREQ_W(FW), .ACC_W(AW), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .en(en), .freq(freq), .mode(mode), .test(test),
    .seed_wr(seed_wr), .seed_ch(seed_ch), .seed_data(seed_data), .dout(dout), .step(step)
  );

  noise_gen_multi #(.NCH(1), .FREQ_W(16), .ACC_W(17), .SEED(SEED)) dut2 (
    .clk(clk), .rst(r2), .en(en2), .freq(freq2), .mode(mode2), .test(test2),
    .seed_wr(sw2), .seed_ch(sch2), .seed_data(sd2), .dout(dout2), .step(step2_v)
  );
  assign step2 = step2_v[0];

  function automatic logic [7:0] tap8(input logic [22:0] l);
    return {l[22], l[20], l[16], l[13], l[11], l[7], l[4], l[2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs after the coming edge, derived from the current inputs
  task automatic model_step();
    logic [NCH*8-1:0] ed;
    logic [NCH-1:0]   es;
    for (int ch = 0; ch < NCH; ch++) begin
      logic [AW-1:0] an;
      logic          stp, hit, lock;
      an   = en ? m_acc[ch] + {{(AW-FW){1'b0}}, freq[ch*FW +: FW]} : m_acc[ch];
      stp  = en && !m_acc[ch][AW-1] && an[AW-1];
      hit  = seed_wr && (int'(seed_ch) == ch);
      lock = mode[ch] ? (m_lfsr[ch][14:0] == 15'd0) : (m_lfsr[ch] == 23'd0);
      es[ch] = 1'b0;
      if (rst || test[ch]) begin
        m_acc[ch]  = '0;
        m_lfsr[ch] = SEED;
      end else begin
        m_acc[ch] = an;
        if (hit) m_lfsr[ch] = (seed_data == 23'd0) ? SEED : seed_data;
        else if (stp) begin
          es[ch] = 1'b1;
          if (lock) m_lfsr[ch] = SEED;
          else if (mode[ch]) m_lfsr[ch] = {m_lfsr[ch][21:0], m_lfsr[ch][14] ^ m_lfsr[ch][13]};
          else m_lfsr[ch] = {m_lfsr[ch][21:0], m_lfsr[ch][22] ^ m_lfsr[ch][17]};
        end
      end
      ed[ch*8 +: 8] = tap8(m_lfsr[ch]);
    end
    sb.push_back({es, ed});
  endtask

  task automatic cyc();
    logic [NCH*8+NCH-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      check("cycle", 32'({step, dout}), 32'(e));
    end
  endtask

  initial begin
    int cnt;
    logic other;
    logic [22:0] l2;
    logic [7:0]  ref_d[64];
    int k;

    rst = 1; en = 0; freq = '0; mode = '0; test = '0;
    seed_wr = 0; seed_ch = '0; seed_data = '0;
    r2 = 1; en2 = 0; freq2 = '0; mode2 = '0; test2 = '0; sw2 = 0; sch2 = '0; sd2 = '0;

    // 1 reset and hold
    cyc(); cyc();
    rst = 0;
    repeat (20) cyc();
    check("rst_dout", 32'(dout), 32'h707070);
    check("rst_step", 32'(step), 32'd0);

    // 2 single step timing
    freq[0 +: FW] = 16'h8000; en = 1;
    cnt = 0;
    do begin cyc(); cnt++; end while (!step[0] && cnt < 2000);
    check("t2_first", cnt, 256);
    check("t2_dout", 32'(dout[7:0]), 32'h8B);
    cnt = 0;
    do begin cyc(); cnt++; end while (!step[0] && cnt < 2000);
    check("t2_period", cnt, 512);

    // 3 en gating from a cleared accumulator
    en = 0; test[0] = 1; cyc(); test[0] = 0;
    cnt = 0; other = 0;
    do begin
      en = (cnt % 4 == 3);
      cyc(); cnt++;
      other |= |step[2:1];
    end while (!step[0] && cnt < 1200);
    check("t3_first", cnt, 1024);
    check("t3_others", 32'(other), 32'd0);

    // 4 seed loads
    en = 0;
    seed_wr = 1; seed_ch = 2'd1; seed_data = 23'h000001; cyc();
    check("t4_seed1", 32'(dout[15:8]), 32'h00);
    seed_data = 23'd0; cyc();
    check("t4_seed0", 32'(dout[15:8]), 32'h70);
    seed_ch = 2'd3; seed_data = 23'h000001; cyc();
    check("t4_badch", 32'(dout[15:8]), 32'h70);
    seed_wr = 0; cyc();

    // 5 short-mode lockup recovery
    seed_wr = 1; seed_ch = 2'd0; seed_data = 23'h7F8000; mode[0] = 1; cyc();
    seed_wr = 0;
    check("t5_seeded", 32'(dout[7:0]), 32'hE0);
    en = 1; cnt = 0;
    do begin cyc(); cnt++; end while (!step[0] && cnt < 600);
    check("t5_stepped", 32'(step[0]), 32'd1);
    check("t5_recover", 32'(dout[7:0]), 32'h70);

    // random mix; seed writes only while en is low
    for (int i = 0; i < 400; i++) begin
      freq = {16'($urandom), 16'($urandom), 16'($urandom)} | {16'h8000, 16'h4000, 16'h2000};
      en   = ($urandom_range(0, 3) != 0);
      mode = 3'($urandom);
      test = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'd0;
      seed_wr   = !en && ($urandom_range(0, 3) == 0);
      seed_ch   = 2'($urandom);
      seed_data = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
      cyc();
    end
    seed_wr = 0; test = '0; mode = '0;

    // 6 priority: test + seed_wr on a step edge of ch2
    freq = {16'h8000, 16'h0000, 16'h0000}; en = 1;
    cnt = 0;
    while (cnt < 600 && !(!m_acc[2][AW-1] && 1'((m_acc[2] + 24'h8000) >> (AW-1)))) begin
      cyc(); cnt++;
    end
    check("t6_found", 32'(cnt < 600), 32'd1);
    test[2] = 1; seed_wr = 1; seed_ch = 2'd2; seed_data = 23'h000005; cyc();
    test[2] = 0; seed_wr = 0;
    check("t6_step", 32'(step[2]), 32'd0);
    check("t6_dout", 32'(dout[23:16]), 32'h70);
    cnt = 0;
    do begin cyc(); cnt++; end while (!step[2] && cnt < 600);
    check("t6_restart", cnt, 256);

    // rst mid-run
    freq = {16'hF123, 16'hA5A5, 16'h7777}; mode = 3'b010;
    repeat (50) cyc();
    rst = 1; cyc(); rst = 0;
    check("t6_rst_dout", 32'(dout), 32'h707070);
    check("t6_rst_step", 32'(step), 32'd0);
    cyc();

    // short-mode period on a narrow accumulator (a step every two cycles)
    freq2 = 16'hFFFF; mode2 = 1'b1; en2 = 1;
    @(posedge clk); #1; r2 = 0;
    l2 = SEED; k = 0; cnt = 0;
    while (k < 32767 + 80 && cnt < 70000) begin
      @(posedge clk); #1; cnt++;
      if (step2) begin
        k++;
        l2 = {l2[21:0], l2[14] ^ l2[13]};
        if (k >= 17 && k < 81) begin
          ref_d[k-17] = tap8(l2);
          check("p_model", 32'(dout2), 32'(tap8(l2)));
        end
        if (k >= 32767 + 17) check("p_period", 32'(dout2), 32'(ref_d[k-32767-17]));
      end
    end
    check("p_done", k, 32767 + 80);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
